// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory port: the responder FSM encoding,
// the request opcode bits as driven by the MEM stage, the data width, and
// small helpers for byte-lane handling. The cpu top level imports the same
// package so both sides of the port agree on the encodings.
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] data_t;

  // Two-bit state encoding; the unused code 2'b11 recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Request opcode as {mem_write, mem_read}. Both bits set is a conflict.
  typedef logic [1:0] dmem_op_t;

  localparam dmem_op_t DMEM_OP_READ  = 2'b01;
  localparam dmem_op_t DMEM_OP_WRITE = 2'b10;

  // Everything about a request except its address, whose width is a
  // parameter of the responder.
  typedef struct packed {
    dmem_op_t op;
    logic     byte_en;
    data_t    wdata;
  } dmem_req_t;

  // Byte-lane write enables {hi, lo}. Word stores write both lanes; byte
  // stores write the lane picked by the address LSB.
  function automatic logic [1:0] lane_enables(input logic byte_en,
                                              input logic lane_sel);
    if (!byte_en) begin
      return 2'b11;
    end
    return lane_sel ? 2'b10 : 2'b01;
  endfunction

  // Byte stores carry their payload in wdata[7:0]; replicate it onto both
  // lanes so whichever lane is enabled receives it.
  function automatic data_t store_data(input logic byte_en, input data_t wdata);
    return byte_en ? {wdata[7:0], wdata[7:0]} : wdata;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH_WORDS x 16-bit on-chip storage with two byte-lane write enables and
// a registered read port. The read register only loads when rd_en is high,
// so it holds the last loaded word between reads; rd_clr loads zero instead
// of the addressed word (used for out-of-range loads).
//
// Ports
//   clock   in   1      rising-edge clock
//   reset   in   1      synchronous active-high; clears the read register only
//   we      in   2      byte-lane write enables {hi, lo}
//   idx     in   IDX    word index shared by write and read
//   din     in   16     write data (lane-aligned)
//   rd_en   in   1      load the read register this edge
//   rd_clr  in   1      with rd_en: load zero instead of the stored word
//   q       out  16     registered read data
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [1:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  data_t                          din,
  input  logic                           rd_en,
  input  logic                           rd_clr,
  output data_t                          q
);

  data_t mem [DEPTH_WORDS];

  // NOTE: storage has no reset term so it maps onto RAM; only the small
  // read register below is reset.
  always_ff @(posedge clock) begin
    if (we[0]) begin
      mem[idx][7:0] <= din[7:0];
    end
    if (we[1]) begin
      mem[idx][15:8] <= din[15:8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (rd_en) begin
      q <= rd_clr ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Responder side of the pipeline data-memory port. A load/store seen in IDLE
// is captured, held for WAIT_CYCLES wait states, then committed to the array
// (write and/or registered read) on the edge into RESP, where done pulses for
// one cycle. stall freezes the front of the pipeline while the access is in
// flight. Out-of-range addresses and read+write conflicts flag err with done.
//
// Ports
//   clock      in   1       rising-edge clock
//   reset      in   1       synchronous active-high; aborts any access
//   mem_read   in   1       load request
//   mem_write  in   1       store request
//   byte_en    in   1       1 = byte store, 0 = word store
//   addr       in   ADDR_W  byte address; addr[0] selects the byte lane
//   wdata      in   16      store data; byte stores use wdata[7:0]
//   rdata      out  16      last completed load data
//   stall      out  1       pipeline freeze while an access is pending
//   done       out  1       one-cycle completion pulse
//   err        out  1       with done: out of range or read+write conflict
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              byte_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              err
);

  localparam int                IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]        CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;

  dmem_req_t         req_live;
  dmem_req_t         req_q;
  dmem_req_t         req_sel;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_sel;

  logic              req_seen;
  logic              commit;
  logic [ADDR_W-2:0] word_idx;
  logic              sel_oor;
  logic              sel_read;
  logic              sel_write;
  logic              sel_conflict;
  logic              err_q;
  logic [1:0]        arr_we;

  assign req_seen = mem_read | mem_write;
  assign req_live = '{op: {mem_write, mem_read}, byte_en: byte_en, wdata: wdata};

  // ---------------------------------------------------------------------------
  // Operand selection. With zero wait states the commit happens on the edge
  // leaving IDLE, before anything is captured, so IDLE uses the live inputs;
  // every later state uses the captured copy.
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_sel  = req_q;
    addr_sel = addr_q;
    if (state == ST_IDLE) begin
      req_sel  = req_live;
      addr_sel = addr;
    end
  end

  // Word index ignores addr[0], which forces word accesses aligned.
  assign word_idx     = addr_sel[ADDR_W-1:1];
  assign sel_oor      = {1'b0, word_idx} >= DEPTH_LIM;
  assign sel_read     = (req_sel.op == DMEM_OP_READ);
  assign sel_write    = |(req_sel.op & DMEM_OP_WRITE);
  assign sel_conflict = (req_sel.op == (DMEM_OP_READ | DMEM_OP_WRITE));

  // Edge on which the access takes effect. Gating with reset makes a reset
  // in the final wait state drop the pending write.
  always_comb begin
    commit = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: commit = req_seen && (WAIT_CYCLES == 0);
        ST_WAIT: commit = (cnt == 4'd0);
        default: commit = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_seen) begin
          state_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The IDLE stall is combinational so the pipeline freezes in
  // the same cycle the request first appears.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    case (state)
      ST_IDLE: stall = req_seen;
      ST_WAIT: stall = 1'b1;
      ST_RESP: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Wait-state counter and request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (state == ST_IDLE && req_seen) begin
      cnt <= CNT_INIT;
    end else if (state == ST_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q  <= '0;
      addr_q <= '0;
    end else if (state == ST_IDLE && req_seen) begin
      req_q  <= req_live;
      addr_q <= addr;
    end
  end

  // Error flag is latched at commit and presented only during RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= sel_oor | sel_conflict;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Conflicting requests still write; only a pure load updates the
  // read register, so stores and conflicts leave rdata untouched.
  // ---------------------------------------------------------------------------
  assign arr_we = (commit && sel_write && !sel_oor)
                ? lane_enables(req_sel.byte_en, addr_sel[0]) : 2'b00;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clock  (clock),
    .reset  (reset),
    .we     (arr_we),
    .idx    (word_idx[IDX_W-1:0]),
    .din    (store_data(req_sel.byte_en, req_sel.wdata)),
    .rd_en  (commit && sel_read),
    .rd_clr (sel_oor),
    .q      (rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders side by side (WAIT_CYCLES=2 and WAIT_CYCLES=0), each driven
// by its own request signals. A reference model (word array plus last-load
// register) predicts data, err and timing from the access rules directly.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_v [2];
  logic        rd_v    [2];
  logic        wr_v    [2];
  logic        be_v    [2];
  logic [15:0] addr_v  [2];
  logic [15:0] wdata_v [2];
  logic [15:0] rdata_v [2];
  logic        stall_v [2];
  logic        done_v  [2];
  logic        err_v   [2];

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cycle_count = 0;

  always @(posedge clock) cycle_count <= cycle_count + 1;

  dmem_responder #(.ADDR_W(16), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_w2 (
    .clock(clock), .reset(reset_v[0]), .mem_read(rd_v[0]), .mem_write(wr_v[0]),
    .byte_en(be_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata_v[0]),
    .stall(stall_v[0]), .done(done_v[0]), .err(err_v[0]));

  dmem_responder #(.ADDR_W(16), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_w0 (
    .clock(clock), .reset(reset_v[1]), .mem_read(rd_v[1]), .mem_write(wr_v[1]),
    .byte_en(be_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata_v[1]),
    .stall(stall_v[1]), .done(done_v[1]), .err(err_v[1]));

  // Reference model state
  logic [15:0] model_mem   [2][256];
  logic [15:0] model_rdata [2];

  function automatic int wait_of(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_check(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock); #1;
      check("idle_stall", 32'(stall_v[s]), 32'd0);
      check("idle_done",  32'(done_v[s]),  32'd0);
      check("idle_err",   32'(err_v[s]),   32'd0);
      check("idle_rdata", 32'(rdata_v[s]), 32'(model_rdata[s]));
    end
  endtask

  // One complete access: update the model, drive the request at a falling
  // edge, hold it until done, then check timing, err and rdata.
  task automatic access(input int s, input logic rd, input logic wr, input logic be,
                        input logic [15:0] a, input logic [15:0] d, input string tag,
                        output int unsigned done_cycle);
    logic [14:0] idx;
    logic        oor;
    logic        exp_err;
    int          lat;
    int          stalls;
    bit          seen;

    idx     = a[15:1];
    oor     = (idx >= 15'd256);
    exp_err = oor | (rd & wr);
    if (wr && !oor) begin
      if (!be)       model_mem[s][idx[7:0]]       = d;
      else if (a[0]) model_mem[s][idx[7:0]][15:8] = d[7:0];
      else           model_mem[s][idx[7:0]][7:0]  = d[7:0];
    end
    if (rd && !wr) model_rdata[s] = oor ? 16'h0000 : model_mem[s][idx[7:0]];

    @(negedge clock);
    rd_v[s] = rd; wr_v[s] = wr; be_v[s] = be; addr_v[s] = a; wdata_v[s] = d;
    #1;
    lat = 0; stalls = 0; seen = 1'b0;
    while (!seen && lat <= wait_of(s) + 8) begin
      if (done_v[s]) begin
        seen = 1'b1;
      end else begin
        if (stall_v[s]) stalls++;
        @(negedge clock); #1;
        lat++;
      end
    end
    done_cycle = cycle_count;
    check({tag, "/done_seen"},   32'(seen),        32'd1);
    check({tag, "/latency"},     32'(lat),         32'(wait_of(s) + 1));
    check({tag, "/stall_count"}, 32'(stalls),      32'(wait_of(s) + 1));
    check({tag, "/stall_resp"},  32'(stall_v[s]),  32'd0);
    check({tag, "/err"},         32'(err_v[s]),    32'(exp_err));
    check({tag, "/rdata"},       32'(rdata_v[s]),  32'(model_rdata[s]));
    rd_v[s] = 1'b0; wr_v[s] = 1'b0; be_v[s] = 1'b0;
  endtask

  // Reset asserted in the last wait state of a store: the write must vanish.
  task automatic reset_mid(input int s);
    logic [15:0] prior;
    int unsigned dc;
    prior = model_mem[s][8'h20];
    @(negedge clock);
    rd_v[s] = 1'b0; wr_v[s] = 1'b1; be_v[s] = 1'b0; addr_v[s] = 16'h0040; wdata_v[s] = 16'hFFFF;
    repeat (wait_of(s)) @(negedge clock);
    #1;
    check("t6/stall_in_wait", 32'(stall_v[s]), 32'd1);
    reset_v[s] = 1'b1; wr_v[s] = 1'b0;
    @(negedge clock);
    reset_v[s] = 1'b0;
    #1;
    model_rdata[s] = 16'h0000;
    check("t6/stall_after", 32'(stall_v[s]), 32'd0);
    check("t6/done_after",  32'(done_v[s]),  32'd0);
    check("t6/err_after",   32'(err_v[s]),   32'd0);
    check("t6/rdata_reset", 32'(rdata_v[s]), 32'd0);
    idle_check(s, 4);
    access(s, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, "t6_load", dc);
    check("t6/prior_kept", 32'(rdata_v[s]), 32'(prior));
  endtask

  task automatic run_dut(input int s);
    int unsigned d1;
    int unsigned d2;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    int          r;

    // Reset state
    check("reset/rdata", 32'(rdata_v[s]), 32'd0);
    check("reset/stall", 32'(stall_v[s]), 32'd0);
    check("reset/done",  32'(done_v[s]),  32'd0);
    check("reset/err",   32'(err_v[s]),   32'd0);

    // Give every word a known value so later loads are predictable.
    for (int i = 0; i < 256; i++) begin
      access(s, 1'b0, 1'b1, 1'b0, 16'(i * 2), 16'($urandom), "preload", d1);
    end

    // Word store then load
    access(s, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, "t1_store", d1);
    access(s, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, "t1_load", d1);
    check("t1/beef", 32'(rdata_v[s]), 32'h0000BEEF);
    idle_check(s, 1);

    // Byte lanes
    access(s, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h1234, "t2_word", d1);
    access(s, 1'b0, 1'b1, 1'b1, 16'h0021, 16'h00AB, "t2_byte_hi", d1);
    access(s, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, "t2_load1", d1);
    check("t2/ab34", 32'(rdata_v[s]), 32'h0000AB34);
    access(s, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h00CD, "t2_byte_lo", d1);
    access(s, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, "t2_load2", d1);
    check("t2/abcd", 32'(rdata_v[s]), 32'h0000ABCD);

    // Back-to-back loads
    access(s, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, "t3_load_a", d1);
    check("t3/data_a", 32'(rdata_v[s]), 32'h0000BEEF);
    access(s, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, "t3_load_b", d2);
    check("t3/data_b", 32'(rdata_v[s]), 32'h0000ABCD);
    check("t3/gap", d2 - d1, 32'(wait_of(s) + 2));

    // Out of range: 0x0200 aliases word 0 if the range check is missing.
    access(s, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h7777, "t4_store", d1);
    access(s, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000, "t4_load", d1);
    check("t4/zero", 32'(rdata_v[s]), 32'd0);
    access(s, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, "t4_word0", d1);

    // Read+write conflict
    access(s, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, "t5_pre", d1);
    access(s, 1'b1, 1'b1, 1'b0, 16'h0030, 16'h5A5A, "t5_conflict", d1);
    check("t5/rdata_kept", 32'(rdata_v[s]), 32'h0000BEEF);
    access(s, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, "t5_load", d1);
    check("t5/written", 32'(rdata_v[s]), 32'h00005A5A);

    if (wait_of(s) > 0) reset_mid(s);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      r  = int'($urandom_range(0, 9));
      rd = (r <= 4);
      wr = (r >= 4);
      a  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h01FF));
      access(s, rd, wr, 1'($urandom_range(0, 1)), a, 16'($urandom), "rand", d1);
      r = int'($urandom_range(0, 2));
      if (r > 0) idle_check(s, r);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      reset_v[s] = 1'b1; rd_v[s] = 1'b0; wr_v[s] = 1'b0; be_v[s] = 1'b0;
      addr_v[s] = 16'h0000; wdata_v[s] = 16'h0000; model_rdata[s] = 16'h0000;
    end
    repeat (3) @(negedge clock);
    reset_v[0] = 1'b0;
    reset_v[1] = 1'b0;
    #1;
    run_dut(0);
    run_dut(1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
